// File: rtl/rtc_arb_pkg.sv
// Shared constants and state encoding for the RTC bus arbiter.
package rtc_arb_pkg;
  localparam int unsigned N_REQ  = 3;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned REQ_INIT = 0;
  localparam int unsigned REQ_CONF = 1;
  localparam int unsigned REQ_READ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rtc_arb_pick.sv
// Combinational winner select: init sequencer has absolute priority,
// configuration writer and periodic reader share a round-robin slot.
module rtc_arb_pick
  import rtc_arb_pkg::*;
(
  input  logic [N_REQ-1:0] in_req,
  input  logic             ptr,
  output logic [N_REQ-1:0] winner
);

  // ptr = 0 favours the configuration writer, ptr = 1 the periodic reader.
  always_comb begin
    winner = '0;
    if (in_req[REQ_INIT])
      winner[REQ_INIT] = 1'b1;
    else if (in_req[REQ_CONF] && (!ptr || !in_req[REQ_READ]))
      winner[REQ_CONF] = 1'b1;
    else if (in_req[REQ_READ])
      winner[REQ_READ] = 1'b1;
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Three-requester arbiter in front of the RTC transaction engine.
// Optional BUSY timeout enabled by defining RTC_ARB_TIMEOUT_EN.
module rtc_bus_arbiter
  import rtc_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          in_req,
  input  logic [N_REQ*ADDR_W-1:0]   in_addr,
  input  logic [N_REQ*DATA_W-1:0]   in_dato,
  input  logic [N_REQ-1:0]          in_w_r,
  input  logic                      in_flag_done,
  input  logic [DATA_W-1:0]         in_dato_leido,
  output logic                      out_en_funcion_rtc,
  output logic [ADDR_W-1:0]         out_addr_ram_rtc,
  output logic [DATA_W-1:0]         out_dato_escritura,
  output logic                      out_funcion_w_r,
  output logic [N_REQ-1:0]          out_gnt,
  output logic [N_REQ-1:0]          out_ack,
  output logic [DATA_W-1:0]         out_rd_dato,
  output logic                      out_busy,
  output logic                      out_err
);

  arb_state_t         state;
  logic               rr_ptr;
  logic [N_REQ-1:0]   winner;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_dato;
  logic               sel_w_r;

  rtc_arb_pick u_pick (
    .in_req (in_req),
    .ptr    (rr_ptr),
    .winner (winner)
  );

  always_comb begin
    sel_addr = '0;
    sel_dato = '0;
    sel_w_r  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        sel_addr = in_addr[i*ADDR_W +: ADDR_W];
        sel_dato = in_dato[i*DATA_W +: DATA_W];
        sel_w_r  = in_w_r[i];
      end
    end
  end

`ifdef RTC_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      rr_ptr             <= 1'b0;
      out_en_funcion_rtc <= 1'b0;
      out_addr_ram_rtc   <= '0;
      out_dato_escritura <= '0;
      out_funcion_w_r    <= 1'b0;
      out_gnt            <= '0;
      out_ack            <= '0;
      out_rd_dato        <= '0;
      out_busy           <= 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
      to_cnt             <= '0;
      err_q              <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|in_req) begin
            state              <= ST_BUSY;
            out_gnt            <= winner;
            out_en_funcion_rtc <= 1'b1;
            out_busy           <= 1'b1;
            out_addr_ram_rtc   <= sel_addr;
            out_dato_escritura <= sel_dato;
            out_funcion_w_r    <= sel_w_r;
            // Pointer moves past whichever of {1,2} was just granted.
            if (winner[REQ_CONF])
              rr_ptr <= 1'b1;
            else if (winner[REQ_READ])
              rr_ptr <= 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (in_flag_done) begin
            state              <= ST_ACK;
            out_en_funcion_rtc <= 1'b0;
            out_ack            <= out_gnt;
            out_rd_dato        <= out_funcion_w_r ? '0 : in_dato_leido;
          end
`ifdef RTC_ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state              <= ST_ACK;
            out_en_funcion_rtc <= 1'b0;
            out_ack            <= out_gnt;
            out_rd_dato        <= '0;
            err_q              <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_ACK: begin
          state       <= ST_IDLE;
          out_ack     <= '0;
          out_gnt     <= '0;
          out_busy    <= 1'b0;
          out_rd_dato <= '0;
`ifdef RTC_ARB_TIMEOUT_EN
          err_q       <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed self-checking bench for rtc_bus_arbiter (timeout case runs when
// RTC_ARB_TIMEOUT_EN is defined).
module tb_rtc_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_req;
  logic [23:0] in_addr;
  logic [23:0] in_dato;
  logic [2:0]  in_w_r;
  logic        in_flag_done;
  logic [7:0]  in_dato_leido;
  logic        out_en_funcion_rtc;
  logic [7:0]  out_addr_ram_rtc;
  logic [7:0]  out_dato_escritura;
  logic        out_funcion_w_r;
  logic [2:0]  out_gnt;
  logic [2:0]  out_ack;
  logic [7:0]  out_rd_dato;
  logic        out_busy;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.TIMEOUT_CYC(16), .TO_W(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_req             (in_req),
    .in_addr            (in_addr),
    .in_dato            (in_dato),
    .in_w_r             (in_w_r),
    .in_flag_done       (in_flag_done),
    .in_dato_leido      (in_dato_leido),
    .out_en_funcion_rtc (out_en_funcion_rtc),
    .out_addr_ram_rtc   (out_addr_ram_rtc),
    .out_dato_escritura (out_dato_escritura),
    .out_funcion_w_r    (out_funcion_w_r),
    .out_gnt            (out_gnt),
    .out_ack            (out_ack),
    .out_rd_dato        (out_rd_dato),
    .out_busy           (out_busy),
    .out_err            (out_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // en, gnt, ack, busy packed for compact checks: {en, gnt, ack, busy}
  function automatic logic [31:0] ctl();
    return {24'd0, out_en_funcion_rtc, out_gnt, out_ack, out_busy};
  endfunction

  initial begin
    reset = 1'b1; in_req = '0; in_addr = '0; in_dato = '0; in_w_r = '0;
    in_flag_done = 1'b0; in_dato_leido = '0;
    tick(); tick();
    check("reset_ctl", ctl(), 32'b0_000_000_0);
    check("reset_err", {31'd0, out_err}, 0);
    check("reset_addr", {24'd0, out_addr_ram_rtc}, 0);
    reset = 1'b0;

    // Single write from the init sequencer, done during the 5th BUSY cycle.
    in_req = 3'b001; in_addr = 24'h000002; in_dato = 24'h000010; in_w_r = 3'b001;
    tick();
    check("w_ctl", ctl(), 32'b1_001_000_1);
    check("w_addr", {24'd0, out_addr_ram_rtc}, 32'h02);
    check("w_dato", {24'd0, out_dato_escritura}, 32'h10);
    check("w_dir", {31'd0, out_funcion_w_r}, 1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("w_en_hold", {31'd0, out_en_funcion_rtc}, 1);
    end
    in_flag_done = 1'b1; in_dato_leido = 8'hEE;
    tick();
    in_flag_done = 1'b0; in_req = '0;
    check("w_ack_ctl", ctl(), 32'b0_001_001_1);
    check("w_ack_rd", {24'd0, out_rd_dato}, 0);
    tick();
    check("w_idle_ctl", ctl(), 32'b0_000_000_0);

    // Completion pulse while idle must be ignored.
    in_flag_done = 1'b1;
    tick();
    in_flag_done = 1'b0;
    check("idle_done_ctl", ctl(), 32'b0_000_000_0);

    // Requesters 1 and 2 held continuously with reads: 010, 100, 010.
    in_req = 3'b110; in_w_r = 3'b000; in_addr = 24'h271100; in_dato = 24'h000000;
    tick();
    check("rr1_gnt", {29'd0, out_gnt}, 32'b010);
    check("rr1_addr", {24'd0, out_addr_ram_rtc}, 32'h11);
    in_flag_done = 1'b1; in_dato_leido = 8'h21;
    tick();
    in_flag_done = 1'b0;
    check("rr1_ack", {29'd0, out_ack}, 32'b010);
    check("rr1_rd", {24'd0, out_rd_dato}, 32'h21);
    tick();
    check("rr1_idle", ctl(), 32'b0_000_000_0);
    tick();
    check("rr2_gnt", {29'd0, out_gnt}, 32'b100);
    check("rr2_addr", {24'd0, out_addr_ram_rtc}, 32'h27);
    in_flag_done = 1'b1; in_dato_leido = 8'h45;
    tick();
    in_flag_done = 1'b0;
    check("rr2_ack", {29'd0, out_ack}, 32'b100);
    check("rr2_rd", {24'd0, out_rd_dato}, 32'h45);
    tick();
    tick();
    check("rr3_gnt", {29'd0, out_gnt}, 32'b010);
    in_flag_done = 1'b1; in_dato_leido = 8'h66;
    tick();
    in_flag_done = 1'b0; in_req = '0;
    check("rr3_ack", {29'd0, out_ack}, 32'b010);
    tick();

    // Requester 2 drops its request and changes inputs mid-BUSY.
    in_req = 3'b100; in_addr = 24'h270000;
    tick();
    check("drop_gnt", {29'd0, out_gnt}, 32'b100);
    in_req = 3'b000; in_addr = 24'h990000;
    tick();
    check("drop_en", {31'd0, out_en_funcion_rtc}, 1);
    check("drop_addr_busy", {24'd0, out_addr_ram_rtc}, 32'h27);
    in_flag_done = 1'b1; in_dato_leido = 8'h5A;
    tick();
    in_flag_done = 1'b0;
    check("drop_ack", {29'd0, out_ack}, 32'b100);
    check("drop_addr_ack", {24'd0, out_addr_ram_rtc}, 32'h27);
    check("drop_rd", {24'd0, out_rd_dato}, 32'h5A);
    tick();

    // Reset during BUSY.
    in_req = 3'b001; in_addr = 24'h000033; in_w_r = 3'b000;
    tick();
    check("rst_pre_en", {31'd0, out_en_funcion_rtc}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; in_req = '0;
    check("rst_ctl", ctl(), 32'b0_000_000_0);
    check("rst_addr", {24'd0, out_addr_ram_rtc}, 0);
    in_flag_done = 1'b1;
    tick();
    in_flag_done = 1'b0;
    check("rst_idle_ctl", ctl(), 32'b0_000_000_0);

    // All three request: init first, then configuration writer (fresh pointer).
    in_req = 3'b111; in_addr = 24'h030201; in_w_r = 3'b000;
    tick();
    check("all_gnt1", {29'd0, out_gnt}, 32'b001);
    in_flag_done = 1'b1; in_dato_leido = 8'h77;
    tick();
    in_flag_done = 1'b0; in_req = 3'b110;
    check("all_ack1", {29'd0, out_ack}, 32'b001);
    check("all_rd1", {24'd0, out_rd_dato}, 32'h77);
    tick();
    tick();
    check("all_gnt2", {29'd0, out_gnt}, 32'b010);
    check("all_addr2", {24'd0, out_addr_ram_rtc}, 32'h02);
    in_flag_done = 1'b1;
    tick();
    in_flag_done = 1'b0; in_req = '0;
    tick();

`ifdef RTC_ARB_TIMEOUT_EN
    in_req = 3'b001; in_w_r = 3'b000; in_dato_leido = 8'hAB;
    tick();
    check("to_en_first", {31'd0, out_en_funcion_rtc}, 1);
    for (int i = 2; i <= 16; i++) begin
      tick();
      check("to_en_hold", {31'd0, out_en_funcion_rtc}, 1);
    end
    tick();
    in_req = '0;
    check("to_ack", {29'd0, out_ack}, 32'b001);
    check("to_err", {31'd0, out_err}, 1);
    check("to_rd", {24'd0, out_rd_dato}, 0);
    tick();
    check("to_err_clr", {31'd0, out_err}, 0);
`else
    in_req = 3'b001; in_w_r = 3'b000;
    for (int i = 1; i <= 20; i++) tick();
    check("noto_en", {31'd0, out_en_funcion_rtc}, 1);
    check("noto_err", {31'd0, out_err}, 0);
    in_flag_done = 1'b1; in_dato_leido = 8'h3C;
    tick();
    in_flag_done = 1'b0; in_req = '0;
    check("noto_ack", {29'd0, out_ack}, 32'b001);
    check("noto_rd", {24'd0, out_rd_dato}, 32'h3C);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
